mem_access_unit: RTL and testbench

- CPU-side initiator for the single-port, word-indexed data memory. Accepts one load/store request at a time from the MEM pipeline stage over a valid/ready handshake.
- Converts byte addresses to word indices and drives the memory's read-enable, write-enable, address and write-data inputs. Captures read data and returns a one-cycle response pulse.
- Produces a stall for the pipeline while an access is in flight.

---
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Load/store initiator for the single-port word-indexed data memory.
// Define MISALIGN_TRAP_EN to reject accesses whose byte address is not word aligned.
module mem_access_unit #(
   parameter int DATA_W    = 32,
   parameter int MEM_DEPTH = 32,
   parameter int RD_LAT    = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   input  logic              req_write_i,
   input  logic [31:0]       req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              req_ready_o,
   output logic              stall_o,
   output logic              resp_valid_o,
   output logic [DATA_W-1:0] resp_rdata_o,
   output logic              resp_err_o,
   output logic              memRead_o,
   output logic              memWrite_o,
   output logic [31:0]       memAddr_o,
   output logic [DATA_W-1:0] memWriteData_o,
   input  logic [DATA_W-1:0] memReadData_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t      state_r;
   state_t      stateNext_s;
   logic [3:0]  cnt_r;
   logic [3:0]  cntNext_s;
   logic        accept_s;
   logic        misalign_s;
   logic        addrErr_s;
   logic [31:0] wordIdx_s;

   // Pipeline stall is combinational on the incoming valid.
   assign stall_o = req_valid_i & ~req_ready_o;

   // Acceptance and address checks on the incoming request.
   always_comb begin
      wordIdx_s = req_addr_i >> 2;
      accept_s  = req_valid_i & req_ready_o;
`ifdef MISALIGN_TRAP_EN
      misalign_s = (req_addr_i[1:0] != 2'b00);
`else
      misalign_s = 1'b0;
`endif
      addrErr_s = (wordIdx_s >= 32'(MEM_DEPTH)) | misalign_s;
   end

   // Next-state and read-latency counter logic.
   always_comb begin
      stateNext_s = state_r;
      cntNext_s   = cnt_r;
      case (state_r)
         IDLE, RESP: begin
            if (accept_s) begin
               if (addrErr_s) begin
                  stateNext_s = RESP;
                  cntNext_s   = 4'd0;
               end else if (req_write_i) begin
                  stateNext_s = WRITE;
                  cntNext_s   = 4'd0;
               end else begin
                  stateNext_s = READ;
                  cntNext_s   = 4'd1;
               end
            end else begin
               stateNext_s = IDLE;
               cntNext_s   = 4'd0;
            end
         end
         WRITE: begin
            stateNext_s = RESP;
            cntNext_s   = 4'd0;
         end
         READ: begin
            // Counter equals the index of the current READ cycle.
            if (cnt_r >= 4'(RD_LAT)) begin
               stateNext_s = RESP;
               cntNext_s   = 4'd0;
            end else begin
               stateNext_s = READ;
               cntNext_s   = cnt_r + 4'd1;
            end
         end
         default: begin
            stateNext_s = IDLE;
            cntNext_s   = 4'd0;
         end
      endcase
   end

   // State register and registered control outputs decoded from the next state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_r      <= IDLE;
         cnt_r        <= 4'd0;
         req_ready_o  <= 1'b1;
         memRead_o    <= 1'b0;
         memWrite_o   <= 1'b0;
         resp_valid_o <= 1'b0;
      end else begin
         state_r      <= stateNext_s;
         cnt_r        <= cntNext_s;
         req_ready_o  <= (stateNext_s == IDLE) || (stateNext_s == RESP);
         memRead_o    <= (stateNext_s == READ);
         memWrite_o   <= (stateNext_s == WRITE);
         resp_valid_o <= (stateNext_s == RESP);
      end
   end

   // Request latch: address and store data held until the next acceptance.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         memAddr_o      <= 32'd0;
         memWriteData_o <= '0;
      end else if (accept_s) begin
         memAddr_o      <= wordIdx_s;
         memWriteData_o <= req_wdata_i;
      end else begin
         memAddr_o      <= memAddr_o;
         memWriteData_o <= memWriteData_o;
      end
   end

   // Response data/error: updated only on entry to RESP, held otherwise.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         resp_rdata_o <= '0;
         resp_err_o   <= 1'b0;
      end else if (accept_s && addrErr_s) begin
         resp_rdata_o <= '0;
         resp_err_o   <= 1'b1;
      end else if ((state_r == READ) && (stateNext_s == RESP)) begin
         resp_rdata_o <= memReadData_i;
         resp_err_o   <= 1'b0;
      end else if (state_r == WRITE) begin
         resp_rdata_o <= resp_rdata_o;
         resp_err_o   <= 1'b0;
      end else begin
         resp_rdata_o <= resp_rdata_o;
         resp_err_o   <= resp_err_o;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: vector table on an RD_LAT=1 instance, hand sequences on an RD_LAT=3 instance.
module tb_mem_access_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        rdy, rd, wr;
      logic [31:0] maddr, mwd;
      logic        rv, err;
      logic [31:0] rdata;
      logic        stall;
   } out_t;

   typedef struct packed {
      logic        v, w;
      logic [31:0] a, d;
      out_t        e;
   } vec_t;

   int nVec  = 0;
   int nMiss = 0;

   // ---------------- RD_LAT = 1 instance ----------------
   logic        rst1, v1, w1;
   logic [31:0] a1, d1;
   logic        rdy1, stall1, rv1, err1, rd1, wr1;
   logic [31:0] rdata1, maddr1, mwd1, mrd1;
   logic [31:0] mem1 [0:31];

   mem_access_unit #(.DATA_W(32), .MEM_DEPTH(32), .RD_LAT(1)) u1 (
      .clk_i(clk), .rst_i(rst1), .req_valid_i(v1), .req_write_i(w1),
      .req_addr_i(a1), .req_wdata_i(d1), .req_ready_o(rdy1), .stall_o(stall1),
      .resp_valid_o(rv1), .resp_rdata_o(rdata1), .resp_err_o(err1),
      .memRead_o(rd1), .memWrite_o(wr1), .memAddr_o(maddr1),
      .memWriteData_o(mwd1), .memReadData_i(mrd1)
   );

   assign mrd1 = rd1 ? mem1[maddr1[4:0]] : 32'h0;
   always @(posedge clk) if (wr1) mem1[maddr1[4:0]] <= mwd1;

   // ---------------- RD_LAT = 3 instance ----------------
   logic        rst3, v3, w3;
   logic [31:0] a3, d3;
   logic        rdy3, stall3, rv3, err3, rd3, wr3;
   logic [31:0] rdata3, maddr3, mwd3, mrd3;
   logic [31:0] mem3 [0:31];

   mem_access_unit #(.DATA_W(32), .MEM_DEPTH(32), .RD_LAT(3)) u3 (
      .clk_i(clk), .rst_i(rst3), .req_valid_i(v3), .req_write_i(w3),
      .req_addr_i(a3), .req_wdata_i(d3), .req_ready_o(rdy3), .stall_o(stall3),
      .resp_valid_o(rv3), .resp_rdata_o(rdata3), .resp_err_o(err3),
      .memRead_o(rd3), .memWrite_o(wr3), .memAddr_o(maddr3),
      .memWriteData_o(mwd3), .memReadData_i(mrd3)
   );

   assign mrd3 = rd3 ? mem3[maddr3[4:0]] : 32'h0;

   initial begin
      for (int i = 0; i < 32; i++) mem3[i] = 32'h0;
      mem3[0] = 32'h1234_5678;
   end

   function automatic vec_t mk(input logic v, w, input logic [31:0] a, d,
                               input logic rdy, rd, wr, input logic [31:0] ma, md,
                               input logic rv, err, input logic [31:0] rdat, input logic st);
      vec_t r;
      r = {v, w, a, d, rdy, rd, wr, ma, md, rv, err, rdat, st};
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      nVec++;
      if (got !== exp) begin
         nMiss++;
         $display("FAIL %s: got %h, want %h", name, got, exp);
      end
   endtask

   vec_t vecs [19];
   out_t got;
   int   rdCnt, stallCnt, respCyc, busyCnt;
   logic [31:0] respData;
   logic        respErr;

   initial begin
      // Columns: valid write addr wdata | ready rd wr memAddr memWData respValid err rdata stall
      vecs[0]  = mk(1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 32'd0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b0);
      vecs[1]  = mk(1'b1, 1'b1, 32'h10, 32'hDEADBEEF,  1'b1, 1'b0, 1'b0, 32'd0,  32'h0,         1'b0, 1'b0, 32'h0,         1'b0);
      vecs[2]  = mk(1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 1'b1, 32'd4,  32'hDEADBEEF,  1'b0, 1'b0, 32'h0,         1'b0);
      vecs[3]  = mk(1'b1, 1'b0, 32'h10, 32'h0,         1'b1, 1'b0, 1'b0, 32'd4,  32'hDEADBEEF,  1'b1, 1'b0, 32'h0,         1'b0);
      vecs[4]  = mk(1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 1'b0, 32'd4,  32'h0,         1'b0, 1'b0, 32'h0,         1'b0);
      vecs[5]  = mk(1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 32'd4,  32'h0,         1'b1, 1'b0, 32'hDEADBEEF,  1'b0);
      vecs[6]  = mk(1'b1, 1'b0, 32'h80, 32'h0,         1'b1, 1'b0, 1'b0, 32'd4,  32'h0,         1'b0, 1'b0, 32'hDEADBEEF,  1'b0);
      vecs[7]  = mk(1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 32'd32, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0);
      vecs[8]  = mk(1'b1, 1'b1, 32'h4,  32'hA5A50001,  1'b1, 1'b0, 1'b0, 32'd32, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0);
      vecs[9]  = mk(1'b1, 1'b1, 32'h8,  32'h00000BB2,  1'b0, 1'b0, 1'b1, 32'd1,  32'hA5A50001,  1'b0, 1'b1, 32'h0,         1'b1);
      vecs[10] = mk(1'b1, 1'b1, 32'h8,  32'h00000BB2,  1'b1, 1'b0, 1'b0, 32'd1,  32'hA5A50001,  1'b1, 1'b0, 32'h0,         1'b0);
      vecs[11] = mk(1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 1'b1, 32'd2,  32'h00000BB2,  1'b0, 1'b0, 32'h0,         1'b0);
      vecs[12] = mk(1'b1, 1'b0, 32'h8,  32'h0,         1'b1, 1'b0, 1'b0, 32'd2,  32'h00000BB2,  1'b1, 1'b0, 32'h0,         1'b0);
      vecs[13] = mk(1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 1'b0, 32'd2,  32'h0,         1'b0, 1'b0, 32'h0,         1'b0);
      vecs[14] = mk(1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 32'd2,  32'h0,         1'b1, 1'b0, 32'h00000BB2,  1'b0);
      vecs[15] = mk(1'b1, 1'b0, 32'h6,  32'h0,         1'b1, 1'b0, 1'b0, 32'd2,  32'h0,         1'b0, 1'b0, 32'h00000BB2,  1'b0);
`ifdef MISALIGN_TRAP_EN
      vecs[16] = mk(1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 32'd1,  32'h0,         1'b1, 1'b1, 32'h0,         1'b0);
      vecs[17] = mk(1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 32'd1,  32'h0,         1'b0, 1'b1, 32'h0,         1'b0);
      vecs[18] = mk(1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 32'd1,  32'h0,         1'b0, 1'b1, 32'h0,         1'b0);
`else
      vecs[16] = mk(1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b1, 1'b0, 32'd1,  32'h0,         1'b0, 1'b0, 32'h00000BB2,  1'b0);
      vecs[17] = mk(1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 32'd1,  32'h0,         1'b1, 1'b0, 32'hA5A50001,  1'b0);
      vecs[18] = mk(1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 1'b0, 32'd1,  32'h0,         1'b0, 1'b0, 32'hA5A50001,  1'b0);
`endif

      rst1 = 1'b1; v1 = 1'b0; w1 = 1'b0; a1 = 32'h0; d1 = 32'h0;
      rst3 = 1'b1; v3 = 1'b0; w3 = 1'b0; a3 = 32'h0; d3 = 32'h0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst1 = 1'b0;
      rst3 = 1'b0;
      #2;
      chk("rst3_ready",  {31'd0, rdy3}, 32'd1);
      chk("rst3_rvalid", {31'd0, rv3},  32'd0);
      chk("rst3_memrw",  {30'd0, rd3, wr3}, 32'd0);
      chk("rst3_addr",   maddr3, 32'd0);

      // Table-driven run on the RD_LAT=1 instance, one row per cycle.
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         v1 = vecs[i].v; w1 = vecs[i].w; a1 = vecs[i].a; d1 = vecs[i].d;
         #2;
         got = {rdy1, rd1, wr1, maddr1, mwd1, rv1, err1, rdata1, stall1};
         nVec++;
         if (got !== vecs[i].e) begin
            nMiss++;
            $display("FAIL vec%0d: got rdy=%b rd=%b wr=%b addr=%h wd=%h rv=%b err=%b rdata=%h stall=%b, want rdy=%b rd=%b wr=%b addr=%h wd=%h rv=%b err=%b rdata=%h stall=%b",
                     i, got.rdy, got.rd, got.wr, got.maddr, got.mwd, got.rv, got.err, got.rdata, got.stall,
                     vecs[i].e.rdy, vecs[i].e.rd, vecs[i].e.wr, vecs[i].e.maddr, vecs[i].e.mwd,
                     vecs[i].e.rv, vecs[i].e.err, vecs[i].e.rdata, vecs[i].e.stall);
         end
      end
      @(negedge clk);
      v1 = 1'b0;

      // RD_LAT=3 load of word 0 with valid held through the busy cycles.
      rdCnt = 0; stallCnt = 0; respCyc = -1; respData = 32'h0; respErr = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         v3 = (c <= 3); w3 = 1'b0; a3 = 32'h0;
         #2;
         if (rd3) rdCnt++;
         if (stall3) stallCnt++;
         if (rv3 && respCyc < 0) begin
            respCyc  = c;
            respData = rdata3;
            respErr  = err3;
         end
      end
      chk("lat3_read_cycles",  rdCnt,    32'd3);
      chk("lat3_stall_cycles", stallCnt, 32'd3);
      chk("lat3_resp_cycle",   respCyc,  32'd4);
      chk("lat3_rdata",        respData, 32'h1234_5678);
      chk("lat3_err",          {31'd0, respErr}, 32'd0);

      // Reset asserted while the RD_LAT=3 load is in READ.
      @(negedge clk);
      v3 = 1'b1; a3 = 32'h0;
      @(negedge clk);
      v3 = 1'b0;
      #2;
      chk("abort_in_read", {31'd0, rd3}, 32'd1);
      @(negedge clk);
      rst3 = 1'b1;
      @(negedge clk);
      rst3 = 1'b0;
      #2;
      chk("abort_ready", {31'd0, rdy3}, 32'd1);
      chk("abort_rdata", rdata3, 32'h0);
      busyCnt = 0;
      for (int c = 0; c < 6; c++) begin
         if (rv3 || rd3 || wr3) busyCnt++;
         @(negedge clk);
         #2;
      end
      chk("abort_no_pulse", busyCnt, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nMiss);
      $finish;
   end

endmodule
